// File: rtl/ram_init_checker_if.sv
// Bus between the RAM read-check controller and its surroundings:
// sweep control, the RAM read port and the result outputs.
interface ram_init_checker_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5
);
  logic                 start;
  logic                 hold;
  logic [DATAWIDTH-1:0] expValue;
  logic [DATAWIDTH-1:0] rdData;
  logic                 chkEnRd;
  logic [ADDRWIDTH-1:0] chkRdAddr;
  logic                 chkBusy;
  logic                 chkDone;
  logic                 chkPass;
  logic [ADDRWIDTH:0]   errCount;
  logic [ADDRWIDTH-1:0] firstErrAddr;
  logic [DATAWIDTH-1:0] firstErrData;

  // Driver side: sequencer and RAM read data source.
  modport master (
    output start, hold, expValue, rdData,
    input  chkEnRd, chkRdAddr, chkBusy, chkDone, chkPass,
           errCount, firstErrAddr, firstErrData
  );

  // Checker side.
  modport slave (
    input  start, hold, expValue, rdData,
    output chkEnRd, chkRdAddr, chkBusy, chkDone, chkPass,
           errCount, firstErrAddr, firstErrData
  );
endinterface

// File: rtl/ram_init_checker.sv
// Sweeps every RAM address through the read port, compares each returned
// word against a captured expected value and reports pass/fail, the
// mismatch count and the first failing address/data.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; results from the last sweep held stable
// ISSUE | issuing reads 0..DEPTH-1, one per cycle unless hold=1
// DRAIN | all reads issued; waiting for the last tagged read data
module ram_init_checker #(
  parameter int DEPTH     = 32,
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5,
  parameter int RDLATENCY = 1
) (
  input logic               clockCore,
  input logic               resetCore,
  ram_init_checker_if.slave chkBus
);

  localparam int ERRWIDTH = ADDRWIDTH + 1;
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(DEPTH - 1);
  localparam logic [ADDRWIDTH-1:0] ADDR_ONE  = ADDRWIDTH'(1);
  localparam logic [ERRWIDTH-1:0]  ERR_ONE   = ERRWIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 chkEnRd_q, chkEnRd_d;
  logic [ADDRWIDTH-1:0] chkRdAddr_q, chkRdAddr_d;
  logic [ADDRWIDTH-1:0] nxtAddr_q, nxtAddr_d;
  logic                 chkBusy_q, chkBusy_d;
  logic                 chkDone_q, chkDone_d;
  logic [DATAWIDTH-1:0] expReg_q, expReg_d;
  logic [ERRWIDTH-1:0]  errCount_q, errCount_d;
  logic [ADDRWIDTH-1:0] firstErrAddr_q, firstErrAddr_d;
  logic [DATAWIDTH-1:0] firstErrData_q, firstErrData_d;

  // Tag pipeline: marks which cycle's rdData belongs to which address.
  logic                 tagVld_q  [RDLATENCY];
  logic [ADDRWIDTH-1:0] tagAddr_q [RDLATENCY];

  logic                 tagVld;
  logic [ADDRWIDTH-1:0] tagAddr;
  logic                 mismatch;
  logic                 lastCmp;

  assign tagVld   = tagVld_q[RDLATENCY-1];
  assign tagAddr  = tagAddr_q[RDLATENCY-1];
  assign mismatch = tagVld && (chkBus.rdData != expReg_q);
  assign lastCmp  = tagVld && (tagAddr == LAST_ADDR);

  // Next-state and output decode for the sweep controller and comparator.
  always_comb begin
    state_d        = state_q;
    chkEnRd_d      = 1'b0;
    chkRdAddr_d    = chkRdAddr_q;
    nxtAddr_d      = nxtAddr_q;
    chkBusy_d      = chkBusy_q;
    chkDone_d      = chkDone_q;
    expReg_d       = expReg_q;
    errCount_d     = errCount_q;
    firstErrAddr_d = firstErrAddr_q;
    firstErrData_d = firstErrData_q;

    unique case (state_q)
      IDLE: begin
        if (chkBus.start) begin
          expReg_d       = chkBus.expValue;
          errCount_d     = '0;
          firstErrAddr_d = '0;
          firstErrData_d = '0;
          chkDone_d      = 1'b0;
          chkBusy_d      = 1'b1;
          state_d        = ISSUE;
          if (!chkBus.hold) begin
            chkEnRd_d   = 1'b1;
            chkRdAddr_d = '0;
            nxtAddr_d   = ADDR_ONE;
          end else begin
            nxtAddr_d   = '0;
          end
        end
      end
      ISSUE: begin
        if (!chkBus.hold) begin
          chkEnRd_d   = 1'b1;
          chkRdAddr_d = nxtAddr_q;
          nxtAddr_d   = nxtAddr_q + ADDR_ONE;
          // Stop on the last real address so a non power-of-2 depth never wraps.
          if (nxtAddr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (lastCmp) begin
          chkDone_d = 1'b1;
          chkBusy_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Tags are only valid while a sweep is active, so this never
    // collides with the clear done on start in IDLE.
    if (mismatch) begin
      errCount_d = errCount_q + ERR_ONE;
      if (errCount_q == '0) begin
        firstErrAddr_d = tagAddr;
        firstErrData_d = chkBus.rdData;
      end
    end
  end

  // Controller, result and read-port registers.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      state_q        <= IDLE;
      chkEnRd_q      <= 1'b0;
      chkRdAddr_q    <= '0;
      nxtAddr_q      <= '0;
      chkBusy_q      <= 1'b0;
      chkDone_q      <= 1'b0;
      expReg_q       <= '0;
      errCount_q     <= '0;
      firstErrAddr_q <= '0;
      firstErrData_q <= '0;
    end else begin
      state_q        <= state_d;
      chkEnRd_q      <= chkEnRd_d;
      chkRdAddr_q    <= chkRdAddr_d;
      nxtAddr_q      <= nxtAddr_d;
      chkBusy_q      <= chkBusy_d;
      chkDone_q      <= chkDone_d;
      expReg_q       <= expReg_d;
      errCount_q     <= errCount_d;
      firstErrAddr_q <= firstErrAddr_d;
      firstErrData_q <= firstErrData_d;
    end
  end

  // Delay the issued read enable/address by the RAM read latency;
  // reset drops any reads still in flight.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      for (int i = 0; i < RDLATENCY; i++) begin
        tagVld_q[i]  <= 1'b0;
        tagAddr_q[i] <= '0;
      end
    end else begin
      tagVld_q[0]  <= chkEnRd_q;
      tagAddr_q[0] <= chkRdAddr_q;
      for (int i = 1; i < RDLATENCY; i++) begin
        tagVld_q[i]  <= tagVld_q[i-1];
        tagAddr_q[i] <= tagAddr_q[i-1];
      end
    end
  end

  assign chkBus.chkEnRd      = chkEnRd_q;
  assign chkBus.chkRdAddr    = chkRdAddr_q;
  assign chkBus.chkBusy      = chkBusy_q;
  assign chkBus.chkDone      = chkDone_q;
  assign chkBus.chkPass      = chkDone_q && (errCount_q == '0);
  assign chkBus.errCount     = errCount_q;
  assign chkBus.firstErrAddr = firstErrAddr_q;
  assign chkBus.firstErrData = firstErrData_q;

endmodule

// File: tb/tb_ram_init_checker.sv
// Bench for ram_init_checker: two instances (DEPTH=32/RDLATENCY=2 and
// DEPTH=20/RDLATENCY=4), each with a latency-accurate RAM model, checked
// against expectations computed from the RAM contents.
module tb_ram_init_checker;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clockCore = 1'b0;
  logic resetCore = 1'b0;
  always #5 clockCore = ~clockCore;

  ram_init_checker_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus_a ();
  ram_init_checker_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus_b ();

  ram_init_checker #(.DEPTH(32), .DATAWIDTH(DW), .ADDRWIDTH(AW), .RDLATENCY(2)) dut_a (
    .clockCore (clockCore),
    .resetCore (resetCore),
    .chkBus    (bus_a)
  );

  ram_init_checker #(.DEPTH(20), .DATAWIDTH(DW), .ADDRWIDTH(AW), .RDLATENCY(4)) dut_b (
    .clockCore (clockCore),
    .resetCore (resetCore),
    .chkBus    (bus_b)
  );

  // RAM contents and read pipelines; non-read cycles return junk.
  logic [DW-1:0] ram [2][32];
  logic [DW-1:0] rp_a [2];
  logic [DW-1:0] rp_b [4];

  always @(posedge clockCore) begin
    rp_a[0] <= bus_a.chkEnRd ? ram[0][bus_a.chkRdAddr] : $urandom;
    rp_a[1] <= rp_a[0];
    rp_b[0] <= bus_b.chkEnRd ? ram[1][bus_b.chkRdAddr] : $urandom;
    for (int i = 1; i < 4; i++) rp_b[i] <= rp_b[i-1];
  end
  assign bus_a.rdData = rp_a[1];
  assign bus_b.rdData = rp_b[3];

  // Indexed views so tasks can address either instance.
  logic          start_v [2];
  logic          hold_v  [2];
  logic [DW-1:0] exp_v   [2];
  assign bus_a.start = start_v[0];  assign bus_b.start = start_v[1];
  assign bus_a.hold  = hold_v[0];   assign bus_b.hold  = hold_v[1];
  assign bus_a.expValue = exp_v[0]; assign bus_b.expValue = exp_v[1];

  logic          m_en    [2];
  logic [AW-1:0] m_addr  [2];
  logic          m_busy  [2];
  logic          m_done  [2];
  logic          m_pass  [2];
  logic [AW:0]   m_err   [2];
  logic [AW-1:0] m_faddr [2];
  logic [DW-1:0] m_fdata [2];
  assign m_en[0] = bus_a.chkEnRd;         assign m_en[1] = bus_b.chkEnRd;
  assign m_addr[0] = bus_a.chkRdAddr;     assign m_addr[1] = bus_b.chkRdAddr;
  assign m_busy[0] = bus_a.chkBusy;       assign m_busy[1] = bus_b.chkBusy;
  assign m_done[0] = bus_a.chkDone;       assign m_done[1] = bus_b.chkDone;
  assign m_pass[0] = bus_a.chkPass;       assign m_pass[1] = bus_b.chkPass;
  assign m_err[0] = bus_a.errCount;       assign m_err[1] = bus_b.errCount;
  assign m_faddr[0] = bus_a.firstErrAddr; assign m_faddr[1] = bus_b.firstErrAddr;
  assign m_fdata[0] = bus_a.firstErrData; assign m_fdata[1] = bus_b.firstErrData;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic int depth_of(input int s);
    return (s == 0) ? 32 : 20;
  endfunction

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : 4;
  endfunction

  task automatic check_all_zero(input int s);
    check_val("zero_en",    m_en[s],    0);
    check_val("zero_addr",  m_addr[s],  0);
    check_val("zero_busy",  m_busy[s],  0);
    check_val("zero_done",  m_done[s],  0);
    check_val("zero_pass",  m_pass[s],  0);
    check_val("zero_err",   m_err[s],   0);
    check_val("zero_faddr", m_faddr[s], 0);
    check_val("zero_fdata", m_fdata[s], 0);
  endtask

  // One sweep. hold_at>=0 freezes the sweep for hold_len cycles once that
  // address is on the port; restart_at>=0 pulses start (with a different
  // expected value) while busy.
  task automatic run_sweep(input int s, input logic [DW-1:0] expv,
                           input int hold_at, input int hold_len, input int restart_at);
    int d, l, errs, faddr, n, done_at, en_cnt, seq_err, busy_err, hold_left, last_addr;
    logic [DW-1:0] fdata;
    logic found, held, hold_req, prev_req;
    d = depth_of(s);
    l = lat_of(s);
    errs = 0; faddr = 0; fdata = '0; found = 1'b0;
    for (int i = 0; i < d; i++) begin
      if (ram[s][i] != expv) begin
        if (!found) begin
          faddr = i;
          fdata = ram[s][i];
          found = 1'b1;
        end
        errs++;
      end
    end

    @(negedge clockCore);
    start_v[s] = 1'b1;
    exp_v[s]   = expv;
    hold_v[s]  = 1'b0;
    @(posedge clockCore);
    #1;
    start_v[s] = 1'b0;
    exp_v[s]   = $urandom;

    n = 0; done_at = 0; en_cnt = 0; seq_err = 0; busy_err = 0;
    hold_left = 0; held = 1'b0; hold_req = 1'b0; last_addr = -1;
    while (done_at == 0 && n < 300) begin
      @(negedge clockCore);
      n++;
      if (m_done[s]) done_at = n;
      else if (!m_busy[s] || m_pass[s]) busy_err++;
      prev_req = hold_req;
      if (prev_req && (m_en[s] || m_addr[s] != AW'(hold_at))) seq_err++;
      if (m_en[s]) begin
        if (m_addr[s] != AW'(en_cnt)) seq_err++;
        en_cnt++;
        last_addr = int'(m_addr[s]);
      end
      if (hold_len > 0 && !held && m_en[s] && m_addr[s] == AW'(hold_at)) begin
        hold_left = hold_len;
        held = 1'b1;
      end
      hold_req = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      // After the last issue, hold must be ignored; toggle it freely.
      hold_v[s] = hold_req | ((en_cnt == d) ? 1'($urandom_range(1)) : 1'b0);
      start_v[s] = (restart_at >= 0 && m_en[s] && m_addr[s] == AW'(restart_at));
      if (start_v[s]) exp_v[s] = ~expv;
    end
    hold_v[s]  = 1'b0;
    start_v[s] = 1'b0;

    check_val("en_cycles",    en_cnt, d);
    check_val("addr_seq",     seq_err, 0);
    check_val("busy_nopass",  busy_err, 0);
    check_val("done_latency", done_at, d + l + 1 + hold_len);
    check_val("last_addr",    last_addr, d - 1);
    check_val("err_count",    m_err[s], errs);
    check_val("pass",         m_pass[s], (errs == 0));
    check_val("first_addr",   m_faddr[s], faddr);
    check_val("first_data",   m_fdata[s], fdata);
    check_val("busy_after",   m_busy[s], 0);

    repeat (3) begin
      @(negedge clockCore);
      hold_v[s] = 1'($urandom_range(1));
    end
    hold_v[s] = 1'b0;
    check_val("results_stable", {m_done[s], m_err[s], m_faddr[s]}, {1'b1, 6'(errs), 5'(faddr)});
  endtask

  // Start a sweep, then pull reset asynchronously once address 15 is issued.
  task automatic reset_mid_sweep(input int s);
    int n;
    @(negedge clockCore);
    start_v[s] = 1'b1;
    exp_v[s]   = 32'h0;
    @(negedge clockCore);
    start_v[s] = 1'b0;
    n = 0;
    while (!(m_en[s] && m_addr[s] == AW'(15)) && n < 100) begin
      @(negedge clockCore);
      n++;
    end
    check_val("reach_addr15", (n < 100), 1);
    #2;
    resetCore = 1'b0;
    #1;
    check_all_zero(s);
    @(negedge clockCore);
    resetCore = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] expv;
    int s, mode, d, hat, hlen, rat;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      hold_v[i]  = 1'b0;
      exp_v[i]   = '0;
      for (int j = 0; j < 32; j++) ram[i][j] = '0;
    end
    resetCore = 1'b0;
    repeat (3) @(negedge clockCore);
    check_all_zero(0);
    check_all_zero(1);
    resetCore = 1'b1;
    @(negedge clockCore);

    // Clean RAM, expected 0.
    run_sweep(0, 32'h0, -1, 0, -1);

    // Two bad words.
    ram[0][7]  = 32'h0000_0001;
    ram[0][20] = 32'hFFFF_FFFF;
    run_sweep(0, 32'h0, -1, 0, -1);

    // Hold for 5 cycles with address 10 on the port.
    run_sweep(0, 32'h0, 10, 5, -1);

    // Non power-of-2 depth, longer latency.
    for (int j = 0; j < 32; j++) ram[1][j] = 32'hA5A5_A5A5;
    run_sweep(1, 32'hA5A5_A5A5, -1, 0, -1);

    // Start while busy must be ignored, including its expected value.
    ram[0][3] = 32'h1234_5678;
    run_sweep(0, 32'h0, -1, 0, 5);

    // Reset mid-sweep, then a clean rerun.
    reset_mid_sweep(0);
    for (int j = 0; j < 32; j++) ram[0][j] = '0;
    run_sweep(0, 32'h0, -1, 0, -1);

    // Randomized sweeps.
    for (int k = 0; k < 8; k++) begin
      s    = int'($urandom_range(1));
      d    = depth_of(s);
      expv = $urandom;
      mode = int'($urandom_range(2));
      for (int j = 0; j < 32; j++) begin
        if (mode == 0) ram[s][j] = expv;
        else if (mode == 1) ram[s][j] = ($urandom_range(7) == 0) ? expv ^ (32'h1 << $urandom_range(31)) : expv;
        else ram[s][j] = $urandom;
      end
      hat  = ($urandom_range(1) == 1) ? int'($urandom_range(d - 2)) : -1;
      hlen = (hat >= 0) ? int'($urandom_range(4, 1)) : 0;
      rat  = ($urandom_range(1) == 1) ? int'($urandom_range(d - 1)) : -1;
      run_sweep(s, expv, hat, hlen, rat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
